// File: rtl/regfile_sb.sv
// regfile_sb
// ----------
// General-purpose register file with a write-back-to-read bypass and a
// per-register pending scoreboard. It sits between decode/issue and
// write-back: decode reads two operands and gets a hazard flag for each,
// so stall logic needs no separate hazard table.
//
// Parameters:
//   DATA_W     register width in bits
//   NUM_REGS   implemented registers, 1 .. 2**ADDR_W
//   ADDR_W     register address width
//   INIT_INDEX 1: reset contents REG[i] = i; 0: all zero
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   src1, src2   read addresses
//   reg1, reg2   read data (combinational, bypassed from write-back)
//   busy1, busy2 source register has an outstanding producer
//   issue_en     an instruction writing issue_dest is issued this cycle
//   issue_dest   destination of the issued instruction
//   writeBackEn  write-back valid
//   Dest_wb      write-back destination
//   Result_WB    write-back data
//   wb_err       one-cycle pulse after a write-back to a non-pending register
//   pending_cnt  number of registers currently pending
module regfile_sb #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 15,
    parameter int ADDR_W     = 4,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              writeBackEn,
    input  logic [ADDR_W-1:0] Dest_wb,
    input  logic [DATA_W-1:0] Result_WB,
    output logic              wb_err,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0]   reg_file_reg [NUM_REGS];
    logic [NUM_REGS-1:0] pending_reg;
    logic [NUM_REGS-1:0] pending_next;
    logic                wb_err_reg;
    logic                wb_err_next;

    // Per-register decode of the issue and write-back destinations.
    // Addresses at or above NUM_REGS match no register, so out-of-range
    // issues and writes fall away naturally.
    logic [NUM_REGS-1:0] set_hit;
    logic [NUM_REGS-1:0] wb_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign set_hit[gi] = issue_en    && (issue_dest == ADDR_W'(gi));
            assign wb_hit[gi]  = writeBackEn && (Dest_wb    == ADDR_W'(gi));
            // A new producer wins over a simultaneous write-back.
            assign pending_next[gi] = set_hit[gi] | (pending_reg[gi] & ~wb_hit[gi]);
        end
    endgenerate

    // Register array. Reset is asynchronous so the whole array is restored
    // immediately, discarding any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                reg_file_reg[r] <= (INIT_INDEX != 0) ? DATA_W'(r) : '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit[r]) begin
                    reg_file_reg[r] <= Result_WB;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            wb_err_reg  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            wb_err_reg  <= wb_err_next;
        end
    end

    // Error flag is judged against the scoreboard before this edge's update;
    // wb_hit is already empty for out-of-range destinations.
    always_comb begin
        wb_err_next = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wb_hit[r] && !pending_reg[r]) begin
                wb_err_next = 1'b1;
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_cnt = pending_cnt + (ADDR_W+1)'(pending_reg[r]);
        end
    end

    // Read ports: select the addressed register, then let a same-cycle
    // write-back override it. An unmatched (out-of-range) address leaves
    // data and busy at zero, and the bypass is qualified by a match too.
    always_comb begin
        reg1  = '0;
        reg2  = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (src1 == ADDR_W'(r)) begin
                reg1  = wb_hit[r] ? Result_WB : reg_file_reg[r];
                busy1 = pending_reg[r] & ~wb_hit[r];
            end
            if (src2 == ADDR_W'(r)) begin
                reg2  = wb_hit[r] ? Result_WB : reg_file_reg[r];
                busy2 = pending_reg[r] & ~wb_hit[r];
            end
        end
    end

    assign wb_err = wb_err_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Two instances share all inputs: one
// with INIT_INDEX = 1 (main checks) and one with INIT_INDEX = 0 (reset
// contents only). Inputs change 1 ns after a rising edge and outputs are
// sampled 1 ns later, well away from the next edge.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] src1, src2;
    logic [DATA_W-1:0] reg1, reg2, reg1_z, reg2_z;
    logic              busy1, busy2, busy1_z, busy2_z;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dest;
    logic              writeBackEn;
    logic [ADDR_W-1:0] Dest_wb;
    logic [DATA_W-1:0] Result_WB;
    logic              wb_err, wb_err_z;
    logic [ADDR_W:0]   pending_cnt, pending_cnt_z;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(15), .ADDR_W(ADDR_W), .INIT_INDEX(1)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
        .busy1(busy1), .busy2(busy2), .issue_en(issue_en), .issue_dest(issue_dest),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
        .wb_err(wb_err), .pending_cnt(pending_cnt)
    );

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(15), .ADDR_W(ADDR_W), .INIT_INDEX(0)) dut_zero (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(reg1_z), .reg2(reg2_z),
        .busy1(busy1_z), .busy2(busy2_z), .issue_en(issue_en), .issue_dest(issue_dest),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
        .wb_err(wb_err_z), .pending_cnt(pending_cnt_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en    = 1'b0;
        writeBackEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        src1 = '0; src2 = '0;
        issue_en = 1'b0; issue_dest = '0;
        writeBackEn = 1'b0; Dest_wb = '0; Result_WB = '0;
        #12;
        rst = 1'b0;

        // Reset contents
        src1 = 4'd5; src2 = 4'd14;
        #1;
        check("rst_reg1", reg1, 32'd5);
        check("rst_reg2", reg2, 32'd14);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        check("rst_cnt", {27'd0, pending_cnt}, 32'd0);
        check("rst_wb_err", {31'd0, wb_err}, 32'd0);
        check("rst_zero_reg1", reg1_z, 32'd0);
        check("rst_zero_reg2", reg2_z, 32'd0);

        // Bypass (register 3 is not pending, so wb_err also pulses)
        tick();
        writeBackEn = 1'b1; Dest_wb = 4'd3; Result_WB = 32'hDEADBEEF; src1 = 4'd3;
        #1;
        check("byp_same_cycle", reg1, 32'hDEADBEEF);
        check("byp_err_not_yet", {31'd0, wb_err}, 32'd0);
        tick();
        idle();
        #1;
        check("byp_after_edge", reg1, 32'hDEADBEEF);
        check("byp_err_pulse", {31'd0, wb_err}, 32'd1);
        tick();
        check("byp_err_cleared", {31'd0, wb_err}, 32'd0);

        // Scoreboard: issue 7, write back three cycles later
        issue_en = 1'b1; issue_dest = 4'd7; src2 = 4'd7;
        #1;
        check("sb_busy_before", {31'd0, busy2}, 32'd0);
        tick();
        idle();
        #1;
        check("sb_busy_k1", {31'd0, busy2}, 32'd1);
        check("sb_cnt_k1", {27'd0, pending_cnt}, 32'd1);
        tick();
        check("sb_busy_k2", {31'd0, busy2}, 32'd1);
        tick();
        writeBackEn = 1'b1; Dest_wb = 4'd7; Result_WB = 32'h0000_0077;
        #1;
        check("sb_busy_wb_cycle", {31'd0, busy2}, 32'd0);
        check("sb_reg2_bypass", reg2, 32'h0000_0077);
        check("sb_cnt_wb_cycle", {27'd0, pending_cnt}, 32'd1);
        tick();
        idle();
        #1;
        check("sb_cnt_k4", {27'd0, pending_cnt}, 32'd0);
        check("sb_no_err", {31'd0, wb_err}, 32'd0);
        check("sb_reg2_array", reg2, 32'h0000_0077);

        // Simultaneous issue and write-back to pending register 2
        issue_en = 1'b1; issue_dest = 4'd2;
        tick();
        issue_en = 1'b1; issue_dest = 4'd2;
        writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'h0000_A5A5; src1 = 4'd2;
        #1;
        check("sim_busy_wb_cycle", {31'd0, busy1}, 32'd0);
        tick();
        idle();
        #1;
        check("sim_same_pending", {31'd0, busy1}, 32'd1);
        check("sim_same_reg", reg1, 32'h0000_A5A5);
        check("sim_same_cnt", {27'd0, pending_cnt}, 32'd1);
        check("sim_same_err", {31'd0, wb_err}, 32'd0);

        // Issue to 4 while writing back 2
        issue_en = 1'b1; issue_dest = 4'd4;
        writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'h0000_1234;
        tick();
        idle();
        src1 = 4'd2; src2 = 4'd4;
        #1;
        check("sim_diff_busy2reg", {31'd0, busy1}, 32'd0);
        check("sim_diff_busy4reg", {31'd0, busy2}, 32'd1);
        check("sim_diff_cnt", {27'd0, pending_cnt}, 32'd1);
        check("sim_diff_reg", reg1, 32'h0000_1234);
        check("sim_diff_err", {31'd0, wb_err}, 32'd0);
        writeBackEn = 1'b1; Dest_wb = 4'd4; Result_WB = 32'h0000_0044;
        tick();
        idle();
        #1;
        check("sim_drain_cnt", {27'd0, pending_cnt}, 32'd0);

        // Write-back to non-pending register 9
        writeBackEn = 1'b1; Dest_wb = 4'd9; Result_WB = 32'h0000_0099; src1 = 4'd9;
        tick();
        idle();
        #1;
        check("err_reg9", reg1, 32'h0000_0099);
        check("err_pulse", {31'd0, wb_err}, 32'd1);
        tick();
        check("err_one_cycle", {31'd0, wb_err}, 32'd0);

        // Out-of-range address 15
        writeBackEn = 1'b1; Dest_wb = 4'd15; Result_WB = 32'h0000_FFFF; src1 = 4'd15;
        #1;
        check("oor_read_bypass", reg1, 32'd0);
        check("oor_busy", {31'd0, busy1}, 32'd0);
        tick();
        idle();
        issue_en = 1'b1; issue_dest = 4'd15;
        #1;
        check("oor_no_err", {31'd0, wb_err}, 32'd0);
        check("oor_read", reg1, 32'd0);
        tick();
        idle();
        #1;
        check("oor_issue_ignored", {27'd0, pending_cnt}, 32'd0);

        // Async reset mid-run with 1, 3 and 6 pending
        writeBackEn = 1'b1; Dest_wb = 4'd5; Result_WB = 32'h0000_0055;
        tick();
        idle();
        issue_en = 1'b1; issue_dest = 4'd1;
        tick();
        issue_dest = 4'd3;
        tick();
        issue_dest = 4'd6;
        tick();
        idle();
        src1 = 4'd5; src2 = 4'd3;
        #1;
        check("ar_cnt_before", {27'd0, pending_cnt}, 32'd3);
        check("ar_reg5_before", reg1, 32'h0000_0055);
        check("ar_busy3_before", {31'd0, busy2}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_cnt", {27'd0, pending_cnt}, 32'd0);
        check("ar_reg5", reg1, 32'd5);
        check("ar_reg3", reg2, 32'd3);
        check("ar_busy3", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        tick();
        check("ar_after_edge_reg5", reg1, 32'd5);
        check("ar_after_edge_cnt", {27'd0, pending_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
